// File: rtl/axis_adder_pipe.sv
// axis_adder_pipe: two-stage AXI-Stream adder summing c_OPERANDS packed operands.
// Stage 1 forms the full-precision sum, stage 2 narrows it to c_OUT_WIDTH and
// flags out-of-range results on m_axis_tuser.
// Optional build macro: AXIS_ADDER_SAT_EN (saturate instead of wrap in stage 2).
module axis_adder_pipe #(
    parameter int c_WIDTH     = 8,
    parameter int c_OPERANDS  = 2,
    parameter int c_SIGNED    = 0,
    parameter int c_OUT_WIDTH = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [c_OPERANDS*c_WIDTH-1:0]   s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [c_OUT_WIDTH-1:0]          m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tuser
);

    // Full-precision width: cannot overflow for c_OPERANDS operands.
    localparam int FW = c_WIDTH + $clog2(c_OPERANDS);
    // Common width wide enough for both the full sum and the result.
    localparam int XW = (c_OUT_WIDTH > FW) ? c_OUT_WIDTH : FW;

    logic                   v1_q;
    logic [FW-1:0]          sum1_q;
    logic [FW-1:0]          sum1_d;
    logic                   v2_q;
    logic [c_OUT_WIDTH-1:0] tdata_q;
    logic [c_OUT_WIDTH-1:0] tdata_d;
    logic                   tuser_q;
    logic                   tuser_d;
    logic [c_WIDTH-1:0]     op;
    logic                   ready2;
    logic                   in_hs;
    logic                   mv12;
    logic [XW-1:0]          ext;
    logic                   ovf;

    // Ready chain: a stage can take data when empty or when its beat leaves.
    assign ready2        = !v2_q || m_axis_tready;
    assign s_axis_tready = !v1_q || ready2;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign mv12          = v1_q && ready2;

    // Extend each operand to FW and accumulate.
    always_comb begin
        sum1_d = '0;
        op     = '0;
        for (int k = 0; k < c_OPERANDS; k++) begin
            op = s_axis_tdata[k*c_WIDTH +: c_WIDTH];
            if (c_SIGNED != 0)
                sum1_d = sum1_d + {{(FW-c_WIDTH){op[c_WIDTH-1]}}, op};
            else
                sum1_d = sum1_d + {{(FW-c_WIDTH){1'b0}}, op};
        end
    end

    // Bring the stage-1 sum to the common width XW.
    generate
        if (XW > FW) begin : g_ext
            assign ext = (c_SIGNED != 0) ? {{(XW-FW){sum1_q[FW-1]}}, sum1_q}
                                         : {{(XW-FW){1'b0}}, sum1_q};
        end else begin : g_noext
            assign ext = sum1_q;
        end
    endgenerate

    // Out of range when the bits above the result do not merely extend it.
    generate
        if (XW > c_OUT_WIDTH) begin : g_ovf
            if (c_SIGNED != 0) begin : g_s
                assign ovf = !((&ext[XW-1:c_OUT_WIDTH-1]) || !(|ext[XW-1:c_OUT_WIDTH-1]));
            end else begin : g_u
                assign ovf = |ext[XW-1:c_OUT_WIDTH];
            end
        end else begin : g_noovf
            assign ovf = 1'b0;
        end
    endgenerate

`ifdef AXIS_ADDER_SAT_EN
    // Saturating reduction: clamp to the nearest representable extreme.
    always_comb begin
        tdata_d = ext[c_OUT_WIDTH-1:0];
        tuser_d = ovf;
        if (ovf) begin
            if (c_SIGNED != 0) begin
                if (ext[XW-1]) begin
                    tdata_d                = '0;
                    tdata_d[c_OUT_WIDTH-1] = 1'b1;
                end else begin
                    tdata_d                = '1;
                    tdata_d[c_OUT_WIDTH-1] = 1'b0;
                end
            end else begin
                tdata_d = '1;
            end
        end
    end
`else
    // Wrapping reduction: keep the low bits, flag the wrap.
    always_comb begin
        tdata_d = ext[c_OUT_WIDTH-1:0];
        tuser_d = ovf;
    end
`endif

    // Stage 1: capture the full sum on an input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sum1_q <= '0;
        end else begin
            if (s_axis_tready) v1_q <= s_axis_tvalid;
            if (in_hs)         sum1_q <= sum1_d;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            tdata_q <= '0;
            tuser_q <= 1'b0;
        end else begin
            if (ready2) v2_q <= v1_q;
            if (mv12) begin
                tdata_q <= tdata_d;
                tuser_q <= tuser_d;
            end
        end
    end

    assign m_axis_tvalid = v2_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_adder_pipe.sv
// Directed bench for axis_adder_pipe: default build plus narrow and signed variants.
module tb_axis_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // u0: defaults (2 x 8-bit unsigned, 9-bit result)
    logic [15:0] s0_d = '0;
    logic        s0_v = 1'b0, s0_r;
    logic [8:0]  m0_d;
    logic        m0_v, m0_u;
    logic        m0_r = 1'b1;
    // u1: defaults with 8-bit result
    logic [15:0] s1_d = '0;
    logic        s1_v = 1'b0, s1_r;
    logic [7:0]  m1_d;
    logic        m1_v, m1_u;
    logic        m1_r = 1'b1;
    // u2: 4 signed operands, 8-bit result
    logic [31:0] s2_d = '0;
    logic        s2_v = 1'b0, s2_r;
    logic [7:0]  m2_d;
    logic        m2_v, m2_u;
    logic        m2_r = 1'b1;

    axis_adder_pipe u0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s0_d), .s_axis_tvalid(s0_v), .s_axis_tready(s0_r),
        .m_axis_tdata(m0_d), .m_axis_tvalid(m0_v), .m_axis_tready(m0_r), .m_axis_tuser(m0_u));

    axis_adder_pipe #(.c_OUT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s1_d), .s_axis_tvalid(s1_v), .s_axis_tready(s1_r),
        .m_axis_tdata(m1_d), .m_axis_tvalid(m1_v), .m_axis_tready(m1_r), .m_axis_tuser(m1_u));

    axis_adder_pipe #(.c_SIGNED(1), .c_OPERANDS(4), .c_OUT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s2_d), .s_axis_tvalid(s2_v), .s_axis_tready(s2_r),
        .m_axis_tdata(m2_d), .m_axis_tvalid(m2_v), .m_axis_tready(m2_r), .m_axis_tuser(m2_u));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ra [100];
    logic [7:0] rb [100];
    logic [8:0] rexp [100];

    initial begin
        // Reset state
        #1;
        check("rst_m0_v", {31'b0, m0_v}, 32'd0);
        check("rst_m0_d", {23'b0, m0_d}, 32'd0);
        check("rst_m0_u", {31'b0, m0_u}, 32'd0);
        check("rst_s0_r", {31'b0, s0_r}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single beat 200+100 into all three instances
        s0_d = 16'h64C8; s0_v = 1'b1;
        s1_d = 16'h64C8; s1_v = 1'b1;
        s2_d = 32'h00FF8080; s2_v = 1'b1;   // -128, -128, -1, 0
        tick();
        s0_v = 1'b0; s1_v = 1'b0; s2_v = 1'b0;
        check("lat1_m0_v", {31'b0, m0_v}, 32'd0);
        tick();
        check("b1_m0_v", {31'b0, m0_v}, 32'd1);
        check("b1_m0_d", {23'b0, m0_d}, 32'h12C);
        check("b1_m0_u", {31'b0, m0_u}, 32'd0);
        check("b1_m1_v", {31'b0, m1_v}, 32'd1);
        check("b1_m1_u", {31'b0, m1_u}, 32'd1);
        check("b1_m2_v", {31'b0, m2_v}, 32'd1);
        check("b1_m2_u", {31'b0, m2_u}, 32'd1);
`ifdef AXIS_ADDER_SAT_EN
        check("b1_m1_d_sat", {24'b0, m1_d}, 32'hFF);
        check("b1_m2_d_sat", {24'b0, m2_d}, 32'h80);
`else
        check("b1_m1_d_wrap", {24'b0, m1_d}, 32'h2C);
        check("b1_m2_d_wrap", {24'b0, m2_d}, 32'hFF);
`endif
        tick();
        check("b1_drain_v", {31'b0, m0_v}, 32'd0);
        tick();

        // Back-to-back stream of 100 beats, tready held high
        for (int i = 0; i < 100; i++) begin
            ra[i]   = 8'($urandom_range(0, 255));
            rb[i]   = 8'($urandom_range(0, 255));
            rexp[i] = {1'b0, ra[i]} + {1'b0, rb[i]};
        end
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                s0_v = 1'b1;
                s0_d = {rb[c], ra[c]};
                check("str_s_rdy", {31'b0, s0_r}, 32'd1);
            end else begin
                s0_v = 1'b0;
            end
            tick();
            check("str_m_v", {31'b0, m0_v}, {31'b0, (c >= 1 && c <= 100)});
            if (c >= 1 && c <= 100) begin
                check("str_m_d", {23'b0, m0_d}, {23'b0, rexp[c-1]});
                check("str_m_u", {31'b0, m0_u}, 32'd0);
            end
        end
        tick();
        check("str_end_v", {31'b0, m0_v}, 32'd0);

        // Backpressure: 5 cycles of m_axis_tready=0 with input valid
        m0_r = 1'b0;
        s0_v = 1'b1; s0_d = 16'h0201;        // A = 3
        check("bp_rdy_a", {31'b0, s0_r}, 32'd1);
        tick();
        s0_d = 16'h0403;                     // B = 7
        check("bp_rdy_b", {31'b0, s0_r}, 32'd1);
        tick();
        s0_d = 16'hF0F0;                     // C = 480
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy_low", {31'b0, s0_r}, 32'd0);
            check("bp_hold_v", {31'b0, m0_v}, 32'd1);
            check("bp_hold_d", {23'b0, m0_d}, 32'd3);
            tick();
        end
        m0_r = 1'b1;
        #1;
        check("bp_rdy_comb", {31'b0, s0_r}, 32'd1);
        tick();
        s0_v = 1'b0;
        check("bp_out_b_v", {31'b0, m0_v}, 32'd1);
        check("bp_out_b_d", {23'b0, m0_d}, 32'd7);
        tick();
        check("bp_out_c_v", {31'b0, m0_v}, 32'd1);
        check("bp_out_c_d", {23'b0, m0_d}, 32'd480);
        tick();
        check("bp_empty_v", {31'b0, m0_v}, 32'd0);

        // Reset with two beats in flight
        m0_r = 1'b0;
        s0_v = 1'b1; s0_d = 16'h1010;
        tick();
        s0_d = 16'h2020;
        tick();
        s0_v = 1'b0;
        check("rf_full_v", {31'b0, m0_v}, 32'd1);
        rst = 1'b1;
        #1;
        check("rf_async_v", {31'b0, m0_v}, 32'd0);
        check("rf_async_d", {23'b0, m0_d}, 32'd0);
        check("rf_async_u", {31'b0, m0_u}, 32'd0);
        tick();
        rst  = 1'b0;
        m0_r = 1'b1;
        #1;
        check("rf_rdy", {31'b0, s0_r}, 32'd1);
        s0_v = 1'b1; s0_d = 16'hFFFF;        // 255+255 = 510
        tick();
        s0_v = 1'b0;
        check("rf_lat_v", {31'b0, m0_v}, 32'd0);
        tick();
        check("rf_post_v", {31'b0, m0_v}, 32'd1);
        check("rf_post_d", {23'b0, m0_d}, 32'd510);
        tick();
        check("rf_no_dup", {31'b0, m0_v}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
